// File: rtl/screen_sequencer.sv
// Purpose: full-screen sequencer; drives the pixel drawer selects through clear/title/flash/play/game-over.
// Latency: selects, busy, game_active lag the internal state by one cycle; plot lags busy by one; sweep_done follows the last select cycle.
// Backpressure: none; every sweep is free-running for exactly PIXELS cycles and cannot be stalled.
module screen_sequencer #(
    parameter int PIXELS      = 19200,
    parameter int FLASH_TICKS = 30,
    parameter int HOLD_TICKS  = 120,
    parameter int CW          = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start_btn,
    input  logic game_over,
    input  logic frame_tick,
    output logic showBlack,
    output logic showTitle,
    output logic flash,
    output logic showGameOver,
    output logic plot,
    output logic sweep_done,
    output logic game_active,
    output logic busy
);

    localparam int TMAX = (FLASH_TICKS > HOLD_TICKS) ? FLASH_TICKS : HOLD_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_CLEAR0,
        S_TITLE,
        S_WAIT,
        S_FSWEEP,
        S_CLEAR1,
        S_PLAY,
        S_GOVER,
        S_HOLD
    } state_t;

    state_t          state;
    logic [CW-1:0]   pix;
    logic [TW-1:0]   tick_cnt;
    logic            phase;
    logic            start_pend;
    logic            last_q;

    logic            in_sweep;
    logic            pix_last;

    // States in which a select line is driven for a full sweep
    assign in_sweep = (state == S_CLEAR0) || (state == S_TITLE) || (state == S_FSWEEP) ||
                      (state == S_CLEAR1) || (state == S_GOVER);
    assign pix_last = in_sweep && (pix == CW'(PIXELS - 1));

    // Sequencer FSM: internal state runs one cycle ahead of the registered select outputs,
    // so the first select cycle lands on the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_CLEAR0;
            pix          <= '0;
            tick_cnt     <= '0;
            phase        <= 1'b0;
            start_pend   <= 1'b0;
            last_q       <= 1'b0;
            showBlack    <= 1'b0;
            showTitle    <= 1'b0;
            flash        <= 1'b0;
            showGameOver <= 1'b0;
            plot         <= 1'b0;
            sweep_done   <= 1'b0;
            game_active  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Registered output decode of the current state
            showBlack    <= (state == S_CLEAR0) || (state == S_CLEAR1);
            showTitle    <= (state == S_TITLE) || ((state == S_FSWEEP) && phase);
            flash        <= (state == S_FSWEEP) && !phase;
            showGameOver <= (state == S_GOVER);
            busy         <= in_sweep;
            plot         <= busy;
            last_q       <= pix_last;
            sweep_done   <= last_q;
            game_active  <= (state == S_PLAY);

            // Pixel counter wraps to 0 exactly at the end of each sweep
            if (in_sweep) begin
                pix <= pix_last ? '0 : pix + CW'(1);
            end

            // A start press during a title-type sweep is remembered until the sweep ends
            if (((state == S_TITLE) || (state == S_FSWEEP)) && start_btn) begin
                start_pend <= 1'b1;
            end

            case (state)
                S_CLEAR0: begin
                    if (pix_last) state <= S_TITLE;
                end
                S_TITLE: begin
                    if (pix_last) begin
                        tick_cnt   <= '0;
                        phase      <= 1'b0;
                        start_pend <= 1'b0;
                        state      <= (start_pend || start_btn) ? S_CLEAR1 : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (start_btn) begin
                        tick_cnt <= '0;
                        state    <= S_CLEAR1;
                    end else if (frame_tick) begin
                        if (tick_cnt == TW'(FLASH_TICKS - 1)) begin
                            tick_cnt <= '0;
                            state    <= S_FSWEEP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                S_FSWEEP: begin
                    if (pix_last) begin
                        phase      <= ~phase;
                        start_pend <= 1'b0;
                        state      <= (start_pend || start_btn) ? S_CLEAR1 : S_WAIT;
                    end
                end
                S_CLEAR1: begin
                    if (pix_last) state <= S_PLAY;
                end
                S_PLAY: begin
                    if (game_over) state <= S_GOVER;
                end
                S_GOVER: begin
                    if (pix_last) begin
                        tick_cnt <= '0;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (frame_tick) begin
                        if (tick_cnt == TW'(HOLD_TICKS - 1)) begin
                            tick_cnt <= '0;
                            state    <= S_TITLE;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: state <= S_CLEAR0;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_sequencer.sv
// Purpose: self-checking bench for screen_sequencer with a shortened sweep length.
// Latency: outputs sampled on the falling edge; inputs driven on the falling edge.
// Backpressure: not applicable.
module tb_screen_sequencer;

    localparam int P  = 300;
    localparam int FT = 30;
    localparam int HT = 120;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_btn = 1'b0;
    logic game_over = 1'b0;
    logic frame_tick = 1'b0;
    logic showBlack, showTitle, flash, showGameOver;
    logic plot, sweep_done, game_active, busy;
    logic [3:0] sel_v;

    int n_cmp = 0;
    int n_bad = 0;
    int mon_bad = 0;
    int mon_cnt = 0;

    typedef struct {
        int         ticks;
        logic [3:0] exp_sel;
        string      nm;
    } step_t;

    step_t steps[4];

    always #5 clk = ~clk;

    assign sel_v = {showBlack, showTitle, flash, showGameOver};

    screen_sequencer #(
        .PIXELS      (P),
        .FLASH_TICKS (FT),
        .HOLD_TICKS  (HT),
        .CW          (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn    (start_btn),
        .game_over    (game_over),
        .frame_tick   (frame_tick),
        .showBlack    (showBlack),
        .showTitle    (showTitle),
        .flash        (flash),
        .showGameOver (showGameOver),
        .plot         (plot),
        .sweep_done   (sweep_done),
        .game_active  (game_active),
        .busy         (busy)
    );

    // Cycle-by-cycle invariants: one-hot selects, busy, plot lag and sweep_done placement
    logic       prev_busy = 1'b0;
    logic [3:0] prev_sel = 4'b0;
    logic       prev_rst = 1'b0;
    always @(negedge clk) begin
        if (rst && prev_rst) begin
            mon_cnt++;
            if ($countones(sel_v) > 1) mon_bad++;
            if (busy != (sel_v != 4'b0)) mon_bad++;
            if (plot != prev_busy) mon_bad++;
            if (sweep_done != ((prev_sel != 4'b0) && (sel_v != prev_sel))) mon_bad++;
        end
        prev_busy = busy;
        prev_sel  = sel_v;
        prev_rst  = rst;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic quiet(input int n, input string nm);
        int seen;
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy || (sel_v != 4'b0)) seen++;
        end
        chk(nm, seen, 0);
    endtask

    // Waits up to timeout cycles for a sweep on code, then checks its length and the done pulse
    task automatic measure(input logic [3:0] code, input int timeout, input string nm);
        int w;
        int cnt;
        w = 0;
        while ((sel_v != code) && (w < timeout)) begin
            @(negedge clk);
            w++;
        end
        chk({nm, "_sel"}, sel_v, code);
        if (sel_v != code) return;
        cnt = 0;
        while ((sel_v == code) && (cnt < P + 10)) begin
            @(negedge clk);
            cnt++;
        end
        chk({nm, "_len"}, cnt, P);
        chk({nm, "_done"}, sweep_done, 1);
    endtask

    initial begin
        int cnt;
        int w;

        steps[0] = '{FT - 1, 4'b0000, "wait29"};
        steps[1] = '{1,      4'b0010, "flash1"};
        steps[2] = '{FT,     4'b0100, "title2"};
        steps[3] = '{FT,     4'b0010, "flash3"};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sel", sel_v, 0);
        chk("rst_busy", busy, 0);
        chk("rst_plot", plot, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_active", game_active, 0);
        rst = 1'b1;

        // Power-up clear then title, back to back
        @(negedge clk);
        measure(4'b1000, 0, "clear0");
        measure(4'b0100, 0, "title0");
        quiet(20, "wait_idle");
        chk("wait_active", game_active, 0);

        // Flash sequencing in WAIT
        for (int i = 0; i < 4; i++) begin
            ticks(steps[i].ticks);
            if (steps[i].exp_sel == 4'b0) quiet(20, steps[i].nm);
            else measure(steps[i].exp_sel, 5, steps[i].nm);
        end

        // Start pressed mid flash-sweep: sweep completes, then clear straight into play
        ticks(FT);
        w = 0;
        while ((sel_v != 4'b0100) && (w < 10)) begin
            @(negedge clk);
            w++;
        end
        chk("fs_sel", sel_v, 4'b0100);
        cnt = 0;
        while ((sel_v == 4'b0100) && (cnt < P + 10)) begin
            start_btn = (cnt == P / 3);
            @(negedge clk);
            cnt++;
        end
        start_btn = 1'b0;
        chk("fs_len", cnt, P);
        chk("fs_done", sweep_done, 1);
        measure(4'b1000, 0, "clear1");
        chk("play_active", game_active, 1);

        // PLAY ignores start and ticks
        start_btn = 1'b1;
        ticks(40);
        start_btn = 1'b0;
        quiet(10, "play_idle");
        chk("play_still", game_active, 1);

        // Game over: game_active falls as the red fill begins
        game_over = 1'b1;
        @(negedge clk);
        chk("go_active_pre", game_active, 1);
        chk("go_sel_pre", showGameOver, 0);
        @(negedge clk);
        chk("go_active_post", game_active, 0);
        measure(4'b0001, 0, "gover");
        game_over = 1'b0;

        // Hold: start ignored, 119 ticks not enough, 120th returns to title then WAIT
        ticks(60);
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        ticks(HT - 61);
        quiet(20, "hold119");
        ticks(1);
        measure(4'b0100, 5, "hold_title");
        quiet(20, "hold_no_start");
        chk("hold_active", game_active, 0);

        // Start and the 30th tick in the same cycle: start wins
        ticks(FT - 1);
        start_btn  = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        start_btn  = 1'b0;
        frame_tick = 1'b0;
        measure(4'b1000, 3, "st_clear1");
        chk("st_active", game_active, 1);
        quiet(20, "st_no_flash");

        // Reset in the middle of the game-over sweep
        game_over = 1'b1;
        w = 0;
        while ((sel_v != 4'b0001) && (w < 10)) begin
            @(negedge clk);
            w++;
        end
        game_over = 1'b0;
        chk("r_go_sel", sel_v, 4'b0001);
        repeat (P / 2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("r_outs", {sel_v, plot, sweep_done, game_active, busy}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        measure(4'b1000, 0, "r_clear0");
        measure(4'b0100, 0, "r_title");
        quiet(10, "r_wait");

        chk("mon_ran", (mon_cnt > 1000) ? 1 : 0, 1);
        chk("invariants", mon_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Top-level screen controller that drives the full-screen pixel drawer (title / black / game-over / flash select inputs) on the 160x120 3-bit framebuffer.
- Sequences power-up clear, title display, "press start" flashing, hand-off to gameplay, and the game-over screen with a timed hold before returning to title.
- Guarantees each full-screen sweep asserts exactly one select line for exactly PIXELS consecutive cycles, so the drawer's address counter ends each sweep aligned to 0.

Parameters:
PIXELS, 19200, pixels per full-screen sweep (160*120)
FLASH_TICKS, 30, frame_tick pulses between flash toggles in WAIT
HOLD_TICKS, 120, frame_tick pulses the game-over screen is held
CW, 15, pixel counter width (must satisfy 2^CW >= PIXELS)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start_btn  in  1  level, player start request
game_over  in  1  level, from game logic; meaningful only in PLAY
frame_tick  in  1  one-cycle pulse per displayed frame
showBlack  out  1  drawer select: black fill
showTitle  out  1  drawer select: title image
flash  out  1  drawer select: title with red suppressed
showGameOver  out  1  drawer select: red fill
plot  out  1  framebuffer write enable; one-cycle-delayed copy of "any select high", matching drawer RAM read latency
sweep_done  out  1  one-cycle pulse on the cycle after the last select cycle of a sweep
game_active  out  1  high only in PLAY
busy  out  1  high whenever any select line is high

Behaviour:
- Reset (rst=0, async): state=CLEAR0, pix=0, tick_cnt=0, phase=0, start_pend=0. All outputs 0. First select cycle is the first clk edge after rst deasserts.
- At most one select line is high in any cycle (one-hot or all-zero).
- Sweep states assert their select line every cycle. pix increments 0..PIXELS-1. On the cycle with pix==PIXELS-1, the next edge clears pix and takes the exit transition. The line is therefore high for exactly PIXELS cycles.
- States, select line, and exit:
  CLEAR0: showBlack -> TITLE.
  TITLE: showTitle -> WAIT, with tick_cnt=0 and phase=0.
  WAIT: no select. Each frame_tick increments tick_cnt. When a tick arrives with tick_cnt==FLASH_TICKS-1: tick_cnt=0, go to FSWEEP.
  FSWEEP: flash if phase==0, else showTitle. Exit: phase toggles -> WAIT.
  CLEAR1: showBlack -> PLAY.
  PLAY: game_active=1 -> GOVER when game_over==1.
  GOVER: showGameOver -> HOLD, with tick_cnt=0.
  HOLD: no select. Counts frame_tick. When a tick arrives with tick_cnt==HOLD_TICKS-1 -> TITLE.
- Start handling:
  - start_btn==1 in WAIT -> CLEAR1 next edge. Start wins over a simultaneous frame_tick. tick_cnt cleared.
  - start_btn==1 during TITLE or FSWEEP sets start_pend. At sweep end, go to CLEAR1 instead of WAIT; start_pend cleared.
  - start_btn is ignored in CLEAR0, CLEAR1, PLAY, GOVER, HOLD. start_pend cannot set there.
- game_over is ignored outside PLAY. game_active falls on the same edge GOVER is entered.
- frame_tick is ignored in all sweep states and in PLAY. No tick counting carries across states.
- plot and busy are registered such that plot(t) = busy(t-1). plot stays high for one cycle after every sweep, coincident with sweep_done.
- Reset mid-sweep: immediate return to CLEAR0 with pix=0. The drawer shares rst, so addresses stay aligned.

Test Plan:
- Reset release -> showBlack high cycles 1..19200 (19200 cycles), then showTitle 19200 cycles, sweep_done pulses at cycles 19201 and 38401, then all selects 0, state WAIT.
- In WAIT, 30 frame_tick pulses -> flash high 19200 cycles. Another 30 ticks -> showTitle 19200 cycles. A third 30 ticks -> flash again (phase alternates).
- start_btn pulsed at pixel 5000 of an FSWEEP -> sweep completes all 19200 cycles, then showBlack 19200 cycles, then game_active=1. No WAIT cycle in between.
- PLAY with game_over=1 -> game_active falls, showGameOver 19200 cycles, then 120 ticks of no select. start_btn pressed during hold is ignored. Then showTitle sweep, then WAIT.
- start_btn and frame_tick in the same WAIT cycle with tick_cnt=29 -> CLEAR1 entered, no flash sweep.
- rst asserted at pixel 10000 of GOVER -> all outputs 0 immediately. After release, full 19200-cycle showBlack, then showTitle. Check select-cycle count per sweep equals 19200 and plot lags busy by exactly 1 cycle throughout.
